if_fetch: RTL and testbench

Instruction fetch stage of the 8-bit five-stage pipeline. It drives the program ROM's address and read/enable strobes and takes the ROM's asynchronous read data in the same cycle. It assembles one-byte and two-byte instructions into a registered IF/ID slot. The decode stage consumes that slot through a valid/ready handshake, and a single-cycle redirect port flushes the stage. The stage stops fetching on HLT.

---
 rtl/if_fetch.sv | 160 ++++++++++++++++
 tb/tb_if_fetch.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch.sv
// Instruction fetch stage: reads the program ROM byte by byte, assembles one- and
// two-byte instructions into a registered IF/ID slot with a valid/ready handshake.
module if_fetch #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [7:0] rom_addr,
    output logic       rom_read,
    output logic       rom_ena,
    input  logic [7:0] rom_data,
    output logic [7:0] ir_op,
    output logic [7:0] ir_arg,
    output logic       ir_two,
    output logic [7:0] ir_pc,
    output logic       ir_valid,
    input  logic       id_ready,
    input  logic       redirect,
    input  logic [7:0] redirect_pc,
    output logic       halted
);

    typedef enum logic [1:0] {S_OP, S_ARG, S_WAIT, S_HALT} state_e;

    state_e     state_q, state_d;
    logic [7:0] pc_q, pc_d;
    logic [7:0] hold_op_q, hold_op_d;
    logic [7:0] hold_arg_q, hold_arg_d;
    logic       hold_two_q, hold_two_d;
    logic [7:0] hold_pc_q, hold_pc_d;
    logic [7:0] ir_op_q, ir_op_d;
    logic [7:0] ir_arg_q, ir_arg_d;
    logic       ir_two_q, ir_two_d;
    logic [7:0] ir_pc_q, ir_pc_d;
    logic       ir_valid_q, ir_valid_d;
    logic       slot_free;

    function automatic logic is_two_byte(input logic [7:0] op);
        return op[7:5] inside {3'b001, 3'b010, 3'b011};
    endfunction

    function automatic logic is_hlt(input logic [7:0] op);
        return op[7:5] == 3'b111;
    endfunction

    assign slot_free = !ir_valid_q || id_ready;

    // NOTE: sequential state uses non-blocking assignments only; reset is sampled on the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_OP;
            pc_q       <= RESET_PC;
            hold_op_q  <= 8'h00;
            hold_arg_q <= 8'h00;
            hold_two_q <= 1'b0;
            hold_pc_q  <= 8'h00;
            ir_op_q    <= 8'h00;
            ir_arg_q   <= 8'h00;
            ir_two_q   <= 1'b0;
            ir_pc_q    <= 8'h00;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_op_q  <= hold_op_d;
            hold_arg_q <= hold_arg_d;
            hold_two_q <= hold_two_d;
            hold_pc_q  <= hold_pc_d;
            ir_op_q    <= ir_op_d;
            ir_arg_q   <= ir_arg_d;
            ir_two_q   <= ir_two_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    // NOTE: every signal gets a hold default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hold_op_d  = hold_op_q;
        hold_arg_d = hold_arg_q;
        hold_two_d = hold_two_q;
        hold_pc_d  = hold_pc_q;
        ir_op_d    = ir_op_q;
        ir_arg_d   = ir_arg_q;
        ir_two_d   = ir_two_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q && !id_ready;

        if (redirect) begin
            state_d    = S_OP;
            pc_d       = redirect_pc;
            ir_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                S_OP: begin
                    pc_d      = pc_q + 8'd1;
                    hold_op_d = rom_data;
                    hold_pc_d = pc_q;
                    if (is_two_byte(rom_data)) begin
                        state_d = S_ARG;
                    end else if (slot_free) begin
                        ir_op_d    = rom_data;
                        ir_arg_d   = 8'h00;
                        ir_two_d   = 1'b0;
                        ir_pc_d    = pc_q;
                        ir_valid_d = 1'b1;
                        state_d    = is_hlt(rom_data) ? S_HALT : S_OP;
                    end else begin
                        hold_arg_d = 8'h00;
                        hold_two_d = 1'b0;
                        state_d    = S_WAIT;
                    end
                end
                S_ARG: begin
                    pc_d = pc_q + 8'd1;
                    if (slot_free) begin
                        ir_op_d    = hold_op_q;
                        ir_arg_d   = rom_data;
                        ir_two_d   = 1'b1;
                        ir_pc_d    = hold_pc_q;
                        ir_valid_d = 1'b1;
                        state_d    = S_OP;
                    end else begin
                        hold_arg_d = rom_data;
                        hold_two_d = 1'b1;
                        state_d    = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (slot_free) begin
                        ir_op_d    = hold_op_q;
                        ir_arg_d   = hold_arg_q;
                        ir_two_d   = hold_two_q;
                        ir_pc_d    = hold_pc_q;
                        ir_valid_d = 1'b1;
                        state_d    = is_hlt(hold_op_q) ? S_HALT : S_OP;
                    end
                end
                S_HALT: ;
                default: state_d = S_OP;
            endcase
        end
    end

    always_comb begin
        rom_read = rst_n && (state_q == S_OP || state_q == S_ARG);
        rom_ena  = rom_read;
        halted   = (state_q == S_HALT);
    end

    assign rom_addr = pc_q;
    assign ir_op    = ir_op_q;
    assign ir_arg   = ir_arg_q;
    assign ir_two   = ir_two_q;
    assign ir_pc    = ir_pc_q;
    assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenario tasks plus a randomized run scored against
// a program-walk model of the instruction stream.
module tb_if_fetch;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] rom_addr;
    logic       rom_read;
    logic       rom_ena;
    logic [7:0] rom_data;
    logic [7:0] ir_op;
    logic [7:0] ir_arg;
    logic       ir_two;
    logic [7:0] ir_pc;
    logic       ir_valid;
    logic       id_ready;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halted;

    logic [7:0]  rom [256];
    logic [25:0] slot;
    int          checks = 0;
    int          errors = 0;

    assign rom_data = rom[rom_addr];
    assign slot     = {ir_valid, ir_op, ir_arg, ir_two, ir_pc};

    always #5 clk = ~clk;

    if_fetch #(.RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n),
        .rom_addr(rom_addr), .rom_read(rom_read), .rom_ena(rom_ena), .rom_data(rom_data),
        .ir_op(ir_op), .ir_arg(ir_arg), .ir_two(ir_two), .ir_pc(ir_pc), .ir_valid(ir_valid),
        .id_ready(id_ready), .redirect(redirect), .redirect_pc(redirect_pc), .halted(halted)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [36:0] e;
        rst_n = 1'b0; id_ready = 1'b0; redirect = 1'b0; redirect_pc = 8'h00;
        step(); step();
        e = {27'h0, 2'b00, 8'h00};
        checks++;
        if ({slot, halted, rom_read, rom_ena, rom_addr} !== {e[36:11], e[10:0]}) begin
            errors++;
            $display("FAIL reset_values got %h want %h", {slot, halted, rom_read, rom_ena, rom_addr}, e);
        end
        id_ready = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({rom_read, rom_ena, rom_addr} !== {2'b11, 8'h00}) begin
            errors++;
            $display("FAIL reset_first_read got %b%b@%h want 11@00", rom_read, rom_ena, rom_addr);
        end
    endtask

    task automatic test_stream();
        logic [25:0] e;
        step();
        e = {1'b1, 8'h00, 8'h00, 1'b0, 8'h00};
        checks++;
        if (slot !== e) begin errors++; $display("FAIL stream_nop got %h want %h", slot, e); end
        step();
        checks++;
        if (ir_valid !== 1'b0) begin errors++; $display("FAIL stream_bubble got %b want 0", ir_valid); end
        step();
        e = {1'b1, 8'h41, 8'h03, 1'b1, 8'h01};
        checks++;
        if (slot !== e) begin errors++; $display("FAIL stream_ldo got %h want %h", slot, e); end
    endtask

    task automatic test_stall();
        logic [25:0] e;
        e = {1'b1, 8'h41, 8'h03, 1'b1, 8'h01};
        id_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (slot !== e) begin errors++; $display("FAIL stall_hold[%0d] got %h want %h", i, slot, e); end
            if (i >= 1) begin
                checks++;
                if ({rom_read, rom_addr} !== {1'b0, 8'h05}) begin
                    errors++;
                    $display("FAIL stall_rom_idle[%0d] got %b@%h want 0@05", i, rom_read, rom_addr);
                end
            end
        end
        id_ready = 1'b1;
        step();
        e = {1'b1, 8'h42, 8'h04, 1'b1, 8'h03};
        checks++;
        if (slot !== e) begin errors++; $display("FAIL stall_release got %h want %h", slot, e); end
        checks++;
        if ({rom_read, rom_addr} !== {1'b1, 8'h05}) begin
            errors++;
            $display("FAIL stall_resume got %b@%h want 1@05", rom_read, rom_addr);
        end
    endtask

    task automatic test_hlt();
        logic [25:0] e;
        step();
        e = {1'b1, 8'hE0, 8'h00, 1'b0, 8'h05};
        checks++;
        if ({slot, halted, rom_read} !== {e, 2'b10}) begin
            errors++;
            $display("FAIL hlt_load got %h h=%b r=%b want %h h=1 r=0", slot, halted, rom_read, e);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({ir_valid, halted, rom_read} !== 3'b010) begin
                errors++;
                $display("FAIL hlt_stay[%0d] got v=%b h=%b r=%b want v=0 h=1 r=0", i, ir_valid, halted, rom_read);
            end
        end
    endtask

    task automatic test_redirect();
        logic [25:0] e;
        e = {1'b1, 8'hA5, 8'h00, 1'b0, 8'h07};
        id_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h07;
        step();
        redirect = 1'b0;
        checks++;
        if ({ir_valid, halted, rom_read, rom_addr} !== {3'b001, 8'h07}) begin
            errors++;
            $display("FAIL redir_halt got v=%b h=%b r=%b a=%h want 0 0 1 07", ir_valid, halted, rom_read, rom_addr);
        end
        step();
        checks++;
        if (slot !== e) begin errors++; $display("FAIL redir_halt_slot got %h want %h", slot, e); end
        step();
        checks++;
        if ({ir_valid, rom_read, rom_addr} !== {2'b11, 8'h09}) begin
            errors++;
            $display("FAIL redir_arg_setup got v=%b r=%b a=%h want 1 1 09", ir_valid, rom_read, rom_addr);
        end
        redirect = 1'b1;
        step();
        redirect = 1'b0;
        checks++;
        if ({ir_valid, halted, rom_read, rom_addr} !== {3'b001, 8'h07}) begin
            errors++;
            $display("FAIL redir_arg got v=%b h=%b r=%b a=%h want 0 0 1 07", ir_valid, halted, rom_read, rom_addr);
        end
        id_ready = 1'b1;
        step();
        checks++;
        if (slot !== e) begin errors++; $display("FAIL redir_arg_slot got %h want %h", slot, e); end
    endtask

    task automatic test_wrap();
        logic [25:0] e;
        rom[8'hFF] = 8'h61; rom[8'h00] = 8'h05; rom[8'h01] = 8'h80;
        redirect = 1'b1; redirect_pc = 8'hFF;
        step();
        redirect = 1'b0;
        checks++;
        if ({ir_valid, rom_read, rom_addr} !== {2'b01, 8'hFF}) begin
            errors++;
            $display("FAIL wrap_start got v=%b r=%b a=%h want 0 1 ff", ir_valid, rom_read, rom_addr);
        end
        step();
        step();
        e = {1'b1, 8'h61, 8'h05, 1'b1, 8'hFF};
        checks++;
        if ({slot, rom_read, rom_addr} !== {e, 1'b1, 8'h01}) begin
            errors++;
            $display("FAIL wrap_slot got %h r=%b a=%h want %h r=1 a=01", slot, rom_read, rom_addr, e);
        end
    endtask

    task automatic test_reset_mid_stall();
        logic [25:0] e;
        rom[8'h10] = 8'hA1; rom[8'h11] = 8'hA2;
        id_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h10;
        step();
        redirect = 1'b0;
        step();
        step();
        e = {1'b1, 8'hA1, 8'h00, 1'b0, 8'h10};
        checks++;
        if ({slot, rom_read} !== {e, 1'b0}) begin
            errors++;
            $display("FAIL mid_stall_setup got %h r=%b want %h r=0", slot, rom_read, e);
        end
        rst_n = 1'b0;
        step();
        checks++;
        if ({slot, halted, rom_read, rom_ena, rom_addr} !== 37'h0) begin
            errors++;
            $display("FAIL mid_stall_reset got %h", {slot, halted, rom_read, rom_ena, rom_addr});
        end
        rst_n = 1'b1; id_ready = 1'b1;
        #1;
        checks++;
        if ({rom_read, rom_addr} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL mid_stall_first_read got %b@%h want 1@00", rom_read, rom_addr);
        end
        step();
        e = {1'b1, 8'h05, 8'h00, 1'b0, 8'h00};
        checks++;
        if (slot !== e) begin errors++; $display("FAIL mid_stall_drop got %h want %h", slot, e); end
    endtask

    // Model: the slot must deliver the program as decoded by walking the ROM from the
    // last redirect target, in order, ending after an HLT, with held slots stable.
    task automatic test_random();
        logic [7:0]  exp_pc, nxt, e_op, e_arg;
        logic        e_two, ended, redir, pre_ready, pre_halt;
        logic [25:0] pre, e;
        int          transfers = 0;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        exp_pc = 8'h00; ended = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            redir       = (i == 0) || ($urandom_range(0, 31) == 0);
            redirect    = redir;
            redirect_pc = 8'($urandom);
            id_ready    = ($urandom_range(0, 2) != 0);
            pre = slot; pre_ready = id_ready; pre_halt = halted;
            checks++;
            if (rom_ena !== rom_read || (halted && rom_read)) begin
                errors++;
                $display("FAIL rand_strobe[%0d] got ena=%b read=%b halted=%b", i, rom_ena, rom_read, halted);
            end
            step();
            if (redir) begin
                exp_pc = redirect_pc; ended = 1'b0;
                checks++;
                if (ir_valid !== 1'b0) begin errors++; $display("FAIL rand_flush[%0d] got %b want 0", i, ir_valid); end
            end else if (pre[25] && pre_ready) begin
                e_op  = rom[exp_pc];
                e_two = (e_op[7:5] >= 3'd1) && (e_op[7:5] <= 3'd3);
                nxt   = exp_pc + 8'd1;
                e_arg = e_two ? rom[nxt] : 8'h00;
                e     = {1'b1, e_op, e_arg, e_two, exp_pc};
                checks++;
                if (ended || pre !== e || (e_op[7:5] == 3'b111 && !pre_halt)) begin
                    errors++;
                    $display("FAIL rand_xfer[%0d] got %h halted=%b want %h ended=%b", i, pre, pre_halt, e, ended);
                end
                transfers++;
                exp_pc = e_two ? nxt + 8'd1 : nxt;
                if (e_op[7:5] == 3'b111) ended = 1'b1;
            end else if (pre[25]) begin
                checks++;
                if (slot !== pre) begin errors++; $display("FAIL rand_hold[%0d] got %h want %h", i, slot, pre); end
            end
        end
        redirect = 1'b0;
        checks++;
        if (transfers < 100) begin errors++; $display("FAIL rand_progress got %0d want >=100", transfers); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'h00;
        rom[0] = 8'h00; rom[1] = 8'h41; rom[2] = 8'h03; rom[3] = 8'h42; rom[4] = 8'h04;
        rom[5] = 8'hE0; rom[6] = 8'h21; rom[7] = 8'hA5; rom[8] = 8'h2A; rom[9] = 8'h11;
        test_reset();
        test_stream();
        test_stall();
        test_hlt();
        test_redirect();
        test_wrap();
        test_reset_mid_stall();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
